// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter sharing one external data-memory bus between two masters.
// Optional ISSUE timeout is compiled in when DATA_BUS_ARBITER_TIMEOUT_EN is defined.
module data_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        async_rst_n,

    input  logic        req0_valid,
    input  logic        req0_mode,
    input  logic        req0_lock,
    input  logic [29:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_mask,
    output logic        req0_ack,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    output logic        stall0,

    input  logic        req1_valid,
    input  logic        req1_mode,
    input  logic        req1_lock,
    input  logic [29:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_mask,
    output logic        req1_ack,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic        stall1,

    output logic        bus_valid,
    output logic        bus_mode,
    output logic        bus_lock,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_mask,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t state_q, state_d;
    logic   grant, last_grant, owner, owner_valid;
    logic   elig0, elig1, win;
    logic   bus_done, tmo_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign stall0   = req0_valid && !req0_ack;
    assign stall1   = req1_valid && !req1_ack;
    assign bus_done = bus_valid && bus_ack;

`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Held at zero outside ISSUE so every ISSUE entry starts a fresh count.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)         tmo_cnt <= '0;
        else if (state_q != ISSUE) tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + CW'(1);
    end

    assign tmo_hit = (state_q == ISSUE) && !bus_done && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        elig0   = req0_valid && (!owner_valid || !owner);
        elig1   = req1_valid && (!owner_valid ||  owner);
        win     = (elig0 && elig1) ? ~last_grant : elig1;
        state_d = state_q;
        case (state_q)
            IDLE:    if (elig0 || elig1)      state_d = ISSUE;
            ISSUE:   if (bus_done || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            bus_valid   <= 1'b0;
            bus_mode    <= 1'b0;
            bus_lock    <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_mask    <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            owner_valid <= 1'b0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_err    <= 1'b0;
            req1_err    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            req0_err <= 1'b0;
            req1_err <= 1'b0;

            if (state_q == IDLE && state_d == ISSUE) begin
                grant      <= win;
                last_grant <= win;
                bus_valid  <= 1'b1;
                bus_mode   <= win ? req1_mode  : req0_mode;
                bus_lock   <= win ? req1_lock  : req0_lock;
                bus_addr   <= win ? req1_addr  : req0_addr;
                bus_wdata  <= win ? req1_wdata : req0_wdata;
                bus_mask   <= win ? req1_mask  : req0_mask;
            end

            // Ack registers into DONE; a timed-out transaction never leaves the bus locked.
            if (state_q == ISSUE && state_d == DONE) begin
                bus_valid   <= 1'b0;
                owner_valid <= bus_lock && !tmo_hit;
                owner       <= grant;
                if (grant) begin
                    req1_ack <= 1'b1;
                    req1_err <= tmo_hit;
                    if (tmo_hit)        req1_rdata <= '0;
                    else if (!bus_mode) req1_rdata <= bus_rdata;
                end else begin
                    req0_ack <= 1'b1;
                    req0_err <= tmo_hit;
                    if (tmo_hit)        req0_rdata <= '0;
                    else if (!bus_mode) req0_rdata <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter; inputs driven 1 time unit after posedge.
module tb_data_bus_arbiter;

    logic        clk, async_rst_n;
    logic        req0_valid, req0_mode, req0_lock;
    logic [29:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_mask;
    logic        req0_ack, req0_err, stall0;
    logic [31:0] req0_rdata;
    logic        req1_valid, req1_mode, req1_lock;
    logic [29:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_mask;
    logic        req1_ack, req1_err, stall1;
    logic [31:0] req1_rdata;
    logic        bus_valid, bus_mode, bus_lock, bus_ack;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [3:0]  bus_mask;

    int tests_run = 0;
    int fails     = 0;

    data_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_mask(req0_mask),
        .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err), .stall0(stall0),
        .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_mask(req1_mask),
        .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err), .stall1(stall1),
        .bus_valid(bus_valid), .bus_mode(bus_mode), .bus_lock(bus_lock),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mask(bus_mask),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_mode = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0; req0_mask = '0;
        req1_valid = 0; req1_mode = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0; req1_mask = '0;
        bus_ack = 0; bus_rdata = '0;
    endtask

    task automatic apply_reset();
        async_rst_n = 0;
        clear_inputs();
        tick();
        async_rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        async_rst_n = 0;
        clear_inputs();
        #1;
        tick();
        tests_run++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid: got %b want 0", bus_valid); end
        tests_run++; if ({req0_ack, req1_ack, req0_err, req1_err} !== 4'b0) begin fails++; $display("FAIL reset_ack_err: got %b want 0000", {req0_ack, req1_ack, req0_err, req1_err}); end
        tests_run++; if ({bus_addr, bus_mask, bus_lock, bus_mode} !== 36'h0) begin fails++; $display("FAIL reset_bus_fields: got %h want 0", {bus_addr, bus_mask, bus_lock, bus_mode}); end
        tests_run++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h want 0/0", req0_rdata, req1_rdata); end
        async_rst_n = 1;
        #1;
    endtask

    task automatic test_single_read();
        req0_valid = 1; req0_mode = 0; req0_addr = 30'h100;
        #1;
        tests_run++; if (stall0 !== 1'b1 || bus_valid !== 1'b0) begin fails++; $display("FAIL rd_pre: stall0=%b bus_valid=%b want 1/0", stall0, bus_valid); end
        tick();
        tests_run++; if (bus_valid !== 1'b1 || bus_addr !== 30'h100 || bus_mode !== 1'b0) begin fails++; $display("FAIL rd_issue: valid=%b addr=%h mode=%b want 1/100/0", bus_valid, bus_addr, bus_mode); end
        tick();
        tests_run++; if (req0_ack !== 1'b0 || stall0 !== 1'b1) begin fails++; $display("FAIL rd_wait: ack=%b stall=%b want 0/1", req0_ack, stall0); end
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        tests_run++; if (req0_ack !== 1'b1 || req0_rdata !== 32'hDEADBEEF || req0_err !== 1'b0) begin fails++; $display("FAIL rd_done: ack=%b rdata=%h err=%b want 1/deadbeef/0", req0_ack, req0_rdata, req0_err); end
        tests_run++; if (stall0 !== 1'b0 || bus_valid !== 1'b0 || req1_ack !== 1'b0) begin fails++; $display("FAIL rd_done_misc: stall0=%b bus_valid=%b ack1=%b want 0/0/0", stall0, bus_valid, req1_ack); end
        req0_valid = 0; bus_ack = 0; bus_rdata = 32'h0;
        tick();
        tests_run++; if (req0_ack !== 1'b0 || req0_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold: ack=%b rdata=%h want 0/deadbeef", req0_ack, req0_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp_addr;
        apply_reset();
        req0_valid = 1; req0_addr = 30'h10;
        req1_valid = 1; req1_addr = 30'h20;
        bus_ack = 1; bus_rdata = 32'h1111_2222;
        for (int t = 1; t <= 12; t++) begin
            tick();
            tests_run++;
            if (req0_ack !== 1'((t % 6) == 2) || req1_ack !== 1'((t % 6) == 5)) begin
                fails++; $display("FAIL b2b_ack t=%0d: ack0=%b ack1=%b want %b/%b", t, req0_ack, req1_ack, (t % 6) == 2, (t % 6) == 5);
            end
            if ((t % 3) == 1) begin
                exp_addr = ((t % 6) == 1) ? 30'h10 : 30'h20;
                tests_run++;
                if (bus_valid !== 1'b1 || bus_addr !== exp_addr) begin
                    fails++; $display("FAIL b2b_grant t=%0d: valid=%b addr=%h want 1/%h", t, bus_valid, bus_addr, exp_addr);
                end
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock();
        apply_reset();
        req1_valid = 1; req1_mode = 1; req1_lock = 1; req1_addr = 30'h40; req1_wdata = 32'hA5A5_0001; req1_mask = 4'hF;
        tick();
        tests_run++; if (bus_addr !== 30'h40 || bus_lock !== 1'b1 || bus_mode !== 1'b1) begin fails++; $display("FAIL lock_issue1: addr=%h lock=%b mode=%b want 40/1/1", bus_addr, bus_lock, bus_mode); end
        req0_valid = 1; req0_mode = 0; req0_addr = 30'h80;
        bus_ack = 1; bus_rdata = 32'h1234_5678;
        tick();
        tests_run++; if (req1_ack !== 1'b1 || req0_ack !== 1'b0) begin fails++; $display("FAIL lock_done1: ack1=%b ack0=%b want 1/0", req1_ack, req0_ack); end
        req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (bus_valid !== 1'b0 || stall0 !== 1'b1) begin fails++; $display("FAIL lock_hold i=%0d: bus_valid=%b stall0=%b want 0/1", i, bus_valid, stall0); end
        end
        req1_valid = 1; req1_lock = 0; req1_addr = 30'h41;
        tick();
        tests_run++; if (bus_addr !== 30'h41 || bus_lock !== 1'b0) begin fails++; $display("FAIL lock_issue2: addr=%h lock=%b want 41/0", bus_addr, bus_lock); end
        tick();
        tests_run++; if (req1_ack !== 1'b1 || req0_ack !== 1'b0) begin fails++; $display("FAIL lock_done2: ack1=%b ack0=%b want 1/0", req1_ack, req0_ack); end
        req1_valid = 0;
        tick();
        tick();
        tests_run++; if (bus_valid !== 1'b1 || bus_addr !== 30'h80) begin fails++; $display("FAIL lock_release: valid=%b addr=%h want 1/80", bus_valid, bus_addr); end
        tick();
        tests_run++; if (req0_ack !== 1'b1 || req0_rdata !== 32'h1234_5678) begin fails++; $display("FAIL lock_p0_done: ack=%b rdata=%h want 1/12345678", req0_ack, req0_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_write_mask();
        req0_valid = 1; req0_mode = 1; req0_addr = 30'h200; req0_mask = 4'b0011; req0_wdata = 32'h0000_50FF;
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        tests_run++; if (bus_mask !== 4'b0011 || bus_wdata !== 32'h0000_50FF || bus_mode !== 1'b1) begin fails++; $display("FAIL wr_fields: mask=%b wdata=%h mode=%b want 0011/000050ff/1", bus_mask, bus_wdata, bus_mode); end
        tick();
        tests_run++; if (req0_ack !== 1'b1 || req0_rdata !== 32'h1234_5678) begin fails++; $display("FAIL wr_rdata_keep: ack=%b rdata=%h want 1/12345678", req0_ack, req0_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_drop_valid();
        req1_valid = 1; req1_mode = 0; req1_addr = 30'h55;
        tick();
        tests_run++; if (bus_valid !== 1'b1 || bus_addr !== 30'h55) begin fails++; $display("FAIL drop_issue: valid=%b addr=%h want 1/55", bus_valid, bus_addr); end
        req1_valid = 0;
        tick();
        bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        tick();
        tests_run++; if (req1_ack !== 1'b1 || req1_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL drop_done: ack=%b rdata=%h want 1/cafef00d", req1_ack, req1_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_issue();
        req0_valid = 1; req0_mode = 0; req0_addr = 30'h300;
        tick();
        tick();
        async_rst_n = 0;
        req1_valid = 1; req1_addr = 30'h301;
        bus_ack = 1; bus_rdata = 32'hBAD0_BAD0;
        #1;
        tests_run++; if (bus_valid !== 1'b0 || req0_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_now: valid=%b ack0=%b want 0/0", bus_valid, req0_ack); end
        tick();
        async_rst_n = 1;
        #1;
        tests_run++; if (req0_ack !== 1'b0 || req1_ack !== 1'b0 || bus_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_release: ack0=%b ack1=%b valid=%b want 0/0/0", req0_ack, req1_ack, bus_valid); end
        tick();
        tests_run++; if (bus_addr !== 30'h300 || req0_ack !== 1'b0 || req1_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_tie: addr=%h ack0=%b ack1=%b want 300/0/0", bus_addr, req0_ack, req1_ack); end
        tick();
        tests_run++; if (req0_ack !== 1'b1 || req0_rdata !== 32'hBAD0_BAD0) begin fails++; $display("FAIL rst_mid_done: ack0=%b rdata=%h want 1/bad0bad0", req0_ack, req0_rdata); end
        clear_inputs();
        tick();
    endtask

`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req0_valid = 1; req0_addr = 30'h5;
        bus_ack = 1; bus_rdata = 32'hAAAA_5555;
        tick();
        tick();
        tests_run++; if (req0_rdata !== 32'hAAAA_5555) begin fails++; $display("FAIL tmo_pre: rdata=%h want aaaa5555", req0_rdata); end
        req0_lock = 1; bus_ack = 0;
        tick();
        tick();
        tests_run++; if (bus_valid !== 1'b1 || bus_lock !== 1'b1) begin fails++; $display("FAIL tmo_issue: valid=%b lock=%b want 1/1", bus_valid, bus_lock); end
        for (int i = 0; i < 15; i++) begin
            tick();
            tests_run++; if (req0_ack !== 1'b0 || bus_valid !== 1'b1) begin fails++; $display("FAIL tmo_wait i=%0d: ack=%b valid=%b want 0/1", i, req0_ack, bus_valid); end
        end
        tick();
        tests_run++; if (req0_ack !== 1'b1 || req0_err !== 1'b1 || req0_rdata !== 32'h0) begin fails++; $display("FAIL tmo_done: ack=%b err=%b rdata=%h want 1/1/0", req0_ack, req0_err, req0_rdata); end
        req0_valid = 0; req0_lock = 0;
        req1_valid = 1; req1_addr = 30'h66;
        tick();
        tick();
        tests_run++; if (bus_valid !== 1'b1 || bus_addr !== 30'h66) begin fails++; $display("FAIL tmo_unlock: valid=%b addr=%h want 1/66", bus_valid, bus_addr); end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        async_rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_lock();
        test_write_mask();
        test_drop_valid();
        test_reset_mid_issue();
`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single external data-memory bus between two requesters.
- Port 0 is the memory stage (load/store). Port 1 is a secondary master (fetch refill / debug).
- Round-robin arbitration, registered bus issue, wait-state tolerant ack handshake, and bus_lock ownership for atomic sequences.
- Sits between the pipeline memory stage and the memory interconnect; provides per-port stall to the pipeline.

Parameters:
- TIMEOUT_CYCLES, 16: cycles ISSUE may wait for bus_ack before forced completion (used only with the optional feature).

Ports:
- clk  input  1  core clock
- async_rst_n  input  1  asynchronous active-low reset
- reqN_valid  input  1  port N (N=0,1) request; held with all reqN fields stable until reqN_ack
- reqN_mode  input  1  port N memory_mode (1 = write, 0 = read)
- reqN_lock  input  1  port N bus_lock; keep ownership after this transaction
- reqN_addr  input  30  port N word address
- reqN_wdata  input  32  port N write data (already byte-lane adjusted)
- reqN_mask  input  4  port N byte-lane mask
- reqN_ack  output  1  one-cycle completion pulse to port N
- reqN_rdata  output  32  read data, valid while reqN_ack=1
- reqN_err  output  1  timeout completion flag, valid with reqN_ack (constant 0 without feature)
- stallN  output  1  combinational: reqN_valid && !reqN_ack
- bus_valid  output  1  external transaction valid
- bus_mode, bus_lock  output  1 each  registered copies of the winner's fields
- bus_addr  output  30; bus_wdata  output  32; bus_mask  output  4  registered winner fields
- bus_ack  input  1  slave completion (may arrive any cycle ≥ 1 after bus_valid rises)
- bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Reset values: state IDLE, all outputs 0, last_grant=1 (port 0 wins first tie), owner_valid=0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Eligible set = ports with valid=1. If owner_valid=1, only the owner is eligible.
  - One eligible port: it wins. Both eligible: the port != last_grant wins.
  - On a winner: register its fields onto bus_*, set grant=winner and last_grant=winner, go to ISSUE.
  - bus_valid rises on the cycle after the request is first seen (1-cycle issue latency).
- ISSUE:
  - bus_valid=1; bus_* fields held constant.
  - On bus_ack: capture bus_rdata into reqN_rdata[grant], go to DONE.
  - bus_ack with bus_valid=0 is ignored in every state.
- DONE:
  - reqN_ack[grant]=1 for exactly this cycle; bus_valid=0; requests not sampled this cycle (prevents duplicate issue while the requester drops valid).
  - Ownership update: if the captured lock=1, owner_valid=1 and owner=grant; else owner_valid=0.
  - Next state is IDLE.
- Minimum transaction period: 3 cycles (IDLE→ISSUE→DONE). Zero-wait bus: ack in first ISSUE cycle.
- Locked, owner idle: the other port's stall stays 1 indefinitely. Ownership persists until the owner completes a transaction with lock=0.
- reqN_rdata holds its value between acks; write transactions leave reqN_rdata unchanged.
- A requester dropping valid during ISSUE does not abort the bus transaction; its ack is still pulsed in DONE.
- Async reset mid-transaction: returns to IDLE immediately, bus_valid=0, ownership cleared. A pending bus_ack after reset release is ignored.

Optional Feature:
- Macro: DATA_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE. When it reaches TIMEOUT_CYCLES without bus_ack, force DONE.
  - reqN_err=1 with the ack; reqN_rdata is set to 32'h0.
  - Ownership is cleared regardless of lock.
  - The counter clears on entry to ISSUE.
- Undefined: no counter; ISSUE waits forever; reqN_err tied 0.

Test Plan:
- Single read, port 0:
  - Stimulus: req0 addr=30'h100, mode=0; bus_ack on 2nd ISSUE cycle with rdata=32'hDEADBEEF.
  - Response: bus_valid rises 1 cycle after req; req0_ack one pulse with rdata=32'hDEADBEEF; stall0 high until the ack cycle.
- Simultaneous requests from reset:
  - Stimulus: both ports request continuously, zero-wait bus.
  - Response: grants 0,1,0,1; each ack 3 cycles apart; no port starved.
- Lock sequence:
  - Stimulus: port 1 issues lock=1 write to 30'h40; port 0 requests throughout; port 1 then issues lock=0 write.
  - Response: port 0 is not granted until port 1's second ack; bus_lock=1 on the first transaction only.
- Write with mask 4'b0011, wdata=32'h000050FF.
  - Response: bus_mask/bus_wdata match exactly; req0_rdata keeps its prior value.
- Reset during ISSUE:
  - Stimulus: deassert async_rst_n mid-wait, then assert bus_ack after release.
  - Response: bus_valid=0 immediately; no reqN_ack; next tie goes to port 0.
- With DATA_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, bus_ack never asserted.
  - Response: ack with err=1 and rdata=0 exactly 16 ISSUE cycles after entry; lock ownership cleared.
